// File: rtl/rv32_isa.sv
// Shared RV32 ISA encodings plus the M-extension sequencer's state and step count.
package rv32_isa;

  localparam int RegAddrWidth = 5;

  localparam logic [6:0] OpF7MUL = 7'b0000001;

  localparam logic [2:0] OpF3MUL    = 3'b000;
  localparam logic [2:0] OpF3MULH   = 3'b001;
  localparam logic [2:0] OpF3MULHSU = 3'b010;
  localparam logic [2:0] OpF3MULHU  = 3'b011;
  localparam logic [2:0] OpF3DIV    = 3'b100;
  localparam logic [2:0] OpF3DIVU   = 3'b101;
  localparam logic [2:0] OpF3REM    = 3'b110;
  localparam logic [2:0] OpF3REMU   = 3'b111;

  localparam int MulDivSteps = 32;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} muldiv_state_e;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/rv32_muldiv_core.sv
// One shift-add multiply or restoring-divide step per enabled cycle, on operand magnitudes.
// res_o is the sign-corrected result of the step being taken this cycle.
module rv32_muldiv_core
  import rv32_isa::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  input  logic [XLEN-1:0] a_mag_i,
  input  logic [XLEN-1:0] b_mag_i,
  output logic [XLEN-1:0] res_o
);

  // acc_q: {product high, multiplier/product low} for MUL*, low half holds dividend->quotient for DIV*
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_neg;
  logic [XLEN-1:0]   rem_q, rem_d, rem_step;
  logic [XLEN-1:0]   op_q, op_d;
  logic [XLEN:0]     sum, shifted, trial;
  logic              div_mode;

  assign div_mode = is_div(funct3_i);

  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, op_q};
    shifted  = {rem_q, acc_q[XLEN-1]};
    trial    = shifted - {1'b0, op_q};
    acc_step = acc_q;
    rem_step = rem_q;
    if (div_mode) begin
      if (!trial[XLEN]) begin
        rem_step = trial[XLEN-1:0];
        acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
      end else begin
        rem_step = shifted[XLEN-1:0];
        acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      acc_step = {sum, acc_q[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    op_d  = op_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, (div_mode ? a_mag_i : b_mag_i)};
      op_d  = div_mode ? b_mag_i : a_mag_i;
      rem_d = '0;
    end else if (step_i) begin
      acc_d = acc_step;
      rem_d = rem_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      op_q  <= op_d;
    end
  end

  // Sign fix-up: negate the full 64-bit product so MULH* high words borrow correctly.
  assign prod_neg = -acc_step;

  always_comb begin
    res_o = acc_step[XLEN-1:0];
    case (funct3_i)
      OpF3MUL:                         res_o = acc_step[XLEN-1:0];
      OpF3MULH, OpF3MULHSU, OpF3MULHU:
        res_o = (neg_a_i ^ neg_b_i) ? prod_neg[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      OpF3DIV, OpF3DIVU:
        res_o = (neg_a_i ^ neg_b_i) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      OpF3REM, OpF3REMU:               res_o = neg_a_i ? -rem_step : rem_step;
      default:                         res_o = acc_step[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/rv32_muldiv_seq.sv
// RV32 M-extension sequencer: accepts one op, runs 32 datapath steps (or short-cuts
// divide-by-zero / signed overflow), then holds the result until the consumer takes it.
module rv32_muldiv_seq
  import rv32_isa::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = RegAddrWidth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic            busy,
  output muldiv_state_e   dbg_state
);

  localparam int CntW = $clog2(MulDivSteps);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and flush cancels either side.

  muldiv_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             na_q, na_d, nb_q, nb_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic            sa, sb, div_by_zero, overflow, core_load, core_step;
  logic [XLEN-1:0] a_mag, b_mag, special_res, core_res;
  logic [2:0]      core_f3;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (in_funct3)
      OpF3MULH, OpF3DIV, OpF3REM: begin
        sa = in_rs1[XLEN-1];
        sb = in_rs2[XLEN-1];
      end
      OpF3MULHSU: sa = in_rs1[XLEN-1];
      default: ;
    endcase
  end

  assign a_mag       = sa ? -in_rs1 : in_rs1;
  assign b_mag       = sb ? -in_rs2 : in_rs2;
  assign div_by_zero = is_div(in_funct3) && (in_rs2 == '0);
  assign overflow    = ((in_funct3 == OpF3DIV) || (in_funct3 == OpF3REM)) &&
                       (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
  // funct3[1] separates REM* from DIV* within the divide group.
  assign special_res = div_by_zero ? (in_funct3[1] ? in_rs1 : '1)
                                   : (in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    tag_d     = tag_q;
    na_d      = na_q;
    nb_d      = nb_q;
    res_d     = res_q;
    core_load = 1'b0;
    core_step = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (in_valid) begin
          f3_d  = in_funct3;
          tag_d = in_tag;
          na_d  = sa;
          nb_d  = sb;
          if (div_by_zero || overflow) begin
            res_d   = special_res;
            state_d = MD_DONE;
          end else begin
            core_load = 1'b1;
            cnt_d     = CntW'(MulDivSteps - 1);
            state_d   = MD_CALC;
          end
        end
        MD_CALC: begin
          core_step = 1'b1;
          if (cnt_q == '0) begin
            res_d   = core_res;
            state_d = MD_DONE;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        MD_DONE: if (out_ready) state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      tag_q   <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      tag_q   <= tag_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      res_q   <= res_d;
    end
  end

  assign core_f3 = (state_q == MD_IDLE) ? in_funct3 : f3_q;

  rv32_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (core_load),
    .step_i   (core_step),
    .funct3_i (core_f3),
    .neg_a_i  (na_q),
    .neg_b_i  (nb_q),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .res_o    (core_res)
  );

  assign in_ready   = (state_q == MD_IDLE);
  assign out_valid  = (state_q == MD_DONE);
  assign busy       = (state_q != MD_IDLE);
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign dbg_state  = state_q;

endmodule
